int_ctrl: RTL and testbench



---
 rtl/int_ctrl.sv | 172 +++++++++++++++++
 tb/tb_int_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/[mtval]/mstatus through the CSR
// interrupt port, then redirects to mtvec or mepc. Optional mtval write: YADAN_INT_MTVAL_EN.
module int_ctrl #(
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mie_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic [31:0] raddr_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MTVAL   = 32'h0000_0343;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
`ifdef YADAN_INT_MTVAL_EN
    S_W_MTVAL,
`endif
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic        is_mret_q, is_mret_d;

  logic ext_req;
  logic tmr_req;

  generate
    if (RESET_PC_UNUSED != 0) begin : g_param_placeholder
    end
  endgenerate

  assign ext_req = irq_ext_i & global_int_en_i & csr_mie_i[11];
  assign tmr_req = irq_timer_i & global_int_en_i & csr_mie_i[7];
  assign raddr_o = CSR_MSTATUS;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    tval_d       = tval_q;
    is_mret_d    = is_mret_q;
    we_o         = 1'b0;
    waddr_o      = 32'h0;
    data_o       = 32'h0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'h0;
    hold_flag_o  = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // Fixed priority: mret > ecall > ebreak > external > timer.
        if (mret_i) begin
          hold_flag_o = 1'b1;
          is_mret_d   = 1'b1;
          state_d     = S_W_MRET;
        end else if (ecall_i | ebreak_i | ext_req | tmr_req) begin
          hold_flag_o = 1'b1;
          is_mret_d   = 1'b0;
          epc_d       = inst_addr_i;
          tval_d      = inst_addr_i;
          state_d     = S_W_MEPC;
          if (ecall_i)       cause_d = CAUSE_ECALL;
          else if (ebreak_i) cause_d = CAUSE_EBREAK;
          else if (ext_req)  cause_d = CAUSE_EXT;
          else               cause_d = CAUSE_TIMER;
        end
      end
      S_W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = epc_q;
        state_d = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
`ifdef YADAN_INT_MTVAL_EN
        state_d = S_W_MTVAL;
`else
        state_d = S_W_MSTATUS;
`endif
      end
`ifdef YADAN_INT_MTVAL_EN
      S_W_MTVAL: begin
        we_o    = 1'b1;
        waddr_o = CSR_MTVAL;
        data_o  = tval_q;
        state_d = S_W_MSTATUS;
      end
`endif
      S_W_MSTATUS: begin
        // MPIE <- MIE, MIE <- 0
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                   1'b0, csr_mstatus_i[2:0]};
        state_d = S_ASSERT;
      end
      S_W_MRET: begin
        // MIE <- MPIE, MPIE <- 1
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                   csr_mstatus_i[7], csr_mstatus_i[2:0]};
        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = is_mret_q ? csr_mepc_i : csr_mtvec_i;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cause_q   <= 32'h0;
      epc_q     <= 32'h0;
      tval_q    <= 32'h0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      is_mret_q <= is_mret_d;
    end
  end

  logic unused_ok;
`ifdef YADAN_INT_MTVAL_EN
  assign unused_ok = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:0]};
`else
  assign unused_ok = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:0], tval_q};
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a per-cycle trap-schedule model checks every output each
// cycle, and literal expectations pin the key sequences.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_i, ebreak_i, mret_i;
  logic [31:0] inst_addr_i;
  logic        irq_ext_i, irq_timer_i, global_int_en_i;
  logic [31:0] csr_mie_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        we_o;
  logic [31:0] waddr_o, data_o, raddr_o;
  logic        hold_flag_o, int_assert_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  int_ctrl dut (
    .clk(clk), .rst(rst),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .mret_i(mret_i),
    .inst_addr_i(inst_addr_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .global_int_en_i(global_int_en_i),
    .csr_mie_i(csr_mie_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .raddr_o(raddr_o),
    .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  localparam logic [2:0] K_MEPC = 3'd0, K_MCAUSE = 3'd1, K_MTVAL = 3'd2, K_MSTATUS = 3'd3,
                         K_MRET = 3'd4, K_AS_ENTRY = 3'd5, K_AS_RET = 3'd6;
  logic [2:0]  exp_q[$];
  logic [31:0] m_epc, m_cause;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        e_we, e_as, e_hold, ev_trap;
    logic [31:0] e_wa, e_d, e_ad, ms;
    if (chk_en) begin
      e_we = 1'b0; e_as = 1'b0; e_hold = 1'b0;
      e_wa = 32'h0; e_d = 32'h0; e_ad = 32'h0;
      ms = csr_mstatus_i;
      ev_trap = ecall_i | ebreak_i | (irq_ext_i & global_int_en_i & csr_mie_i[11])
              | (irq_timer_i & global_int_en_i & csr_mie_i[7]);
      if (exp_q.size() > 0) begin
        e_hold = 1'b1;
        case (exp_q[0])
          K_MEPC:     begin e_we = 1'b1; e_wa = 32'h341; e_d = m_epc; end
          K_MCAUSE:   begin e_we = 1'b1; e_wa = 32'h342; e_d = m_cause; end
          K_MTVAL:    begin e_we = 1'b1; e_wa = 32'h343; e_d = m_epc; end
          K_MSTATUS:  begin
            e_we = 1'b1; e_wa = 32'h300;
            e_d = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
          end
          K_MRET:     begin
            e_we = 1'b1; e_wa = 32'h300;
            e_d = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
          end
          K_AS_ENTRY: begin e_as = 1'b1; e_ad = csr_mtvec_i; end
          default:    begin e_as = 1'b1; e_ad = csr_mepc_i; end
        endcase
      end else begin
        e_hold = mret_i | ev_trap;
      end
      chk("m_hold", {31'h0, hold_flag_o}, {31'h0, e_hold});
      chk("m_we", {31'h0, we_o}, {31'h0, e_we});
      chk("m_waddr", waddr_o, e_wa);
      chk("m_data", data_o, e_d);
      chk("m_assert", {31'h0, int_assert_o}, {31'h0, e_as});
      chk("m_addr", int_addr_o, e_ad);
      chk("m_raddr", raddr_o, 32'h300);
      // advance the schedule across the coming edge
      if (rst) exp_q.delete();
      else if (exp_q.size() > 0) void'(exp_q.pop_front());
      else if (mret_i) begin
        exp_q.push_back(K_MRET); exp_q.push_back(K_AS_RET);
      end else if (ev_trap) begin
        m_epc = inst_addr_i;
        if (ecall_i) m_cause = 32'd11;
        else if (ebreak_i) m_cause = 32'd3;
        else if (irq_ext_i & global_int_en_i & csr_mie_i[11]) m_cause = 32'h8000_000B;
        else m_cause = 32'h8000_0007;
        exp_q.push_back(K_MEPC); exp_q.push_back(K_MCAUSE);
`ifdef YADAN_INT_MTVAL_EN
        exp_q.push_back(K_MTVAL);
`endif
        exp_q.push_back(K_MSTATUS); exp_q.push_back(K_AS_ENTRY);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // One cycle of literal expectations, then advance to just after the next edge.
  task automatic lit(input string nm, input logic hold, input logic we, input logic [31:0] wa,
                     input logic [31:0] d, input logic as, input logic [31:0] ad);
    @(negedge clk);
    chk({nm, "_hold"}, {31'h0, hold_flag_o}, {31'h0, hold});
    chk({nm, "_we"}, {31'h0, we_o}, {31'h0, we});
    chk({nm, "_waddr"}, waddr_o, wa);
    chk({nm, "_data"}, data_o, d);
    chk({nm, "_assert"}, {31'h0, int_assert_o}, {31'h0, as});
    chk({nm, "_addr"}, int_addr_o, ad);
    step();
  endtask

  task automatic quiet(input string nm);
    lit(nm, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Trap-entry writes following detection; mstatus input assumed 0x8.
  task automatic entry_seq(input string nm, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tvec);
    lit({nm, "_mepc"}, 1'b1, 1'b1, 32'h341, epc, 1'b0, 32'h0);
    lit({nm, "_mcause"}, 1'b1, 1'b1, 32'h342, cause, 1'b0, 32'h0);
`ifdef YADAN_INT_MTVAL_EN
    lit({nm, "_mtval"}, 1'b1, 1'b1, 32'h343, epc, 1'b0, 32'h0);
`endif
    lit({nm, "_mstatus"}, 1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0);
    lit({nm, "_assert"}, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, tvec);
  endtask

  task automatic clear_events();
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
    irq_ext_i = 1'b0; irq_timer_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    clear_events();
    inst_addr_i = 32'h0; global_int_en_i = 1'b0;
    csr_mie_i = 32'h0; csr_mtvec_i = 32'h200; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    quiet("reset");

    // ecall
    inst_addr_i = 32'h100; ecall_i = 1'b1;
    lit("ecall_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    ecall_i = 1'b0;
    entry_seq("ecall", 32'h100, 32'd11, 32'h200);
    quiet("ecall_idle");

    // mret
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; mret_i = 1'b1;
    lit("mret_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    mret_i = 1'b0;
    lit("mret_wr", 1'b1, 1'b1, 32'h300, 32'h88, 1'b0, 32'h0);
    lit("mret_assert", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104);
    quiet("mret_idle");

    // masking
    csr_mstatus_i = 32'h8;
    irq_ext_i = 1'b1; global_int_en_i = 1'b0; csr_mie_i = 32'h800;
    quiet("mask_mie");
    global_int_en_i = 1'b1; csr_mie_i = 32'h080;
    quiet("mask_meie");
    csr_mie_i = 32'h880; inst_addr_i = 32'h40;
    lit("ext_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    irq_ext_i = 1'b0;
    entry_seq("ext", 32'h40, 32'h8000_000B, 32'h200);
    quiet("ext_idle");

    // ecall beats timer
    irq_timer_i = 1'b1; ecall_i = 1'b1; inst_addr_i = 32'h120;
    lit("prio_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    clear_events();
    entry_seq("prio", 32'h120, 32'd11, 32'h200);

    // mret beats external; interrupt taken afterwards once MIE is restored
    mret_i = 1'b1; irq_ext_i = 1'b1; csr_mie_i = 32'h800; csr_mstatus_i = 32'h80;
    csr_mepc_i = 32'h300;
    lit("mx_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    clear_events();
    lit("mx_mret", 1'b1, 1'b1, 32'h300, 32'h88, 1'b0, 32'h0);
    lit("mx_assert", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
    csr_mstatus_i = 32'h8; irq_ext_i = 1'b1; inst_addr_i = 32'h300;
    lit("mx_irq_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    entry_seq("mx_irq", 32'h300, 32'h8000_000B, 32'h200);
    global_int_en_i = 1'b0; csr_mstatus_i = 32'h80;
    quiet("mx_masked");
    clear_events(); csr_mstatus_i = 32'h8;

    // reset during the mcause write
    ebreak_i = 1'b1; inst_addr_i = 32'h80;
    lit("rst_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    ebreak_i = 1'b0;
    lit("rst_mepc", 1'b1, 1'b1, 32'h341, 32'h80, 1'b0, 32'h0);
    rst = 1'b1;
    lit("rst_mcause", 1'b1, 1'b1, 32'h342, 32'd3, 1'b0, 32'h0);
    rst = 1'b0;
    quiet("rst_after0");
    quiet("rst_after1");

    // full ebreak (mtval write at T+3 when enabled)
    ebreak_i = 1'b1; inst_addr_i = 32'h80;
    lit("ebrk_det", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    ebreak_i = 1'b0;
    entry_seq("ebrk", 32'h80, 32'd3, 32'h200);
    quiet("ebrk_idle");

    // varied vectors, model-checked only
    for (int i = 0; i < 300; i++) begin
      ecall_i = ($urandom_range(0, 9) == 0);
      ebreak_i = ($urandom_range(0, 9) == 0);
      mret_i = ($urandom_range(0, 9) == 0);
      irq_ext_i = $urandom_range(0, 1) != 0;
      irq_timer_i = $urandom_range(0, 1) != 0;
      global_int_en_i = ($urandom_range(0, 3) == 0);
      csr_mie_i = $urandom_range(0, 1) ? 32'h880 : {$urandom} & 32'hFFFF_F77F;
      inst_addr_i = {$urandom} & 32'hFFFF_FFFC;
      csr_mstatus_i = $urandom; csr_mtvec_i = $urandom; csr_mepc_i = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    clear_events(); rst = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
